// File: rtl/fwd_scoreboard_pkg.sv
// Shared definitions for the forwarding/hazard scoreboard: forward select
// encodings and the bit layout of one tracked-writer entry.
package fwd_scoreboard_pkg;

  // Forward select encodings seen by the EX operand muxes.
  typedef enum int unsigned {
    FWD_RF    = 0,  // register file / ID/EX value
    FWD_EXMEM = 1,  // EX/MEM pipeline register
    FWD_MEMWB = 2   // MEM/WB pipeline register
  } fwd_sel_e;

  // Entry layout: {rd[AW-1:0], ld, v}
  localparam int ENT_V      = 0;
  localparam int ENT_LD     = 1;
  localparam int ENT_RD_LSB = 2;

  function automatic int ent_width(input int aw);
    return aw + ENT_RD_LSB;
  endfunction

endpackage

// File: rtl/fwd_scoreboard_match.sv
// One source operand checked against every tracked writer. The youngest
// matching writer (lowest stage index) decides the forward select and
// whether the operand is not yet available (latency-use hazard).
module fwd_match
  import fwd_scoreboard_pkg::*;
#(
  parameter int AW       = 5,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 2,
  parameter int SW       = 2,
  parameter int EW       = ent_width(AW)
) (
  input  logic [AW-1:0]             src,
  input  logic                      src_en,
  input  logic [DEPTH-1:0][EW-1:0]  ent,
  output logic [SW-1:0]             sel,
  output logic                      hazard
);

  logic found;

  // Youngest-first priority scan; a writer past the last tracked forward
  // point has already written the RF, so it selects the RF value.
  always_comb begin
    sel    = SW'(FWD_RF);
    hazard = 1'b0;
    found  = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (!found && src_en && (src != '0) && ent[k][ENT_V] &&
          (ent[k][ENT_RD_LSB +: AW] == src)) begin
        found = 1'b1;
        if (k + 1 < DEPTH) sel = SW'(k + 1);
        hazard = ent[k][ENT_LD] && (k + 1 < LOAD_LAT);
      end
    end
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// Hazard/forwarding scoreboard for the in-order integer pipeline. Tracks
// in-flight register writers in the stages after ID, stalls ID on
// latency-use hazards, registers per-source forward selects into EX and
// counts stall cycles.
//
// Handshake: id_valid qualifies the ID instruction; stall acts as the
// inverse of ready. The ID instruction is accepted (enters EX and, if it
// writes a nonzero register, the tracker) in a cycle where
// id_valid & ~stall & ~flush. flush squashes it without stalling.
module fwd_scoreboard
  import fwd_scoreboard_pkg::*;
#(
  parameter int NREG     = 32,
  parameter int AW       = 5,
  parameter int NSRC     = 2,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 2,
  localparam int SW      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic [AW-1:0]        id_rd,
  input  logic                 id_we,
  input  logic                 id_load,
  input  logic [NSRC*AW-1:0]   id_src,
  input  logic [NSRC-1:0]      id_src_used,
  input  logic                 flush,
  output logic                 stall,
  output logic [NSRC*SW-1:0]   ex_fwd_sel,
  output logic [CW-1:0]        busy_cnt,
  output logic [15:0]          stall_cycles
);

  localparam int EW = ent_width(AW);

  logic [DEPTH-1:0][EW-1:0] ent_q, ent_d;
  logic [NSRC*SW-1:0]       ex_fwd_sel_q, ex_fwd_sel_d;
  logic [15:0]              stall_cycles_q, stall_cycles_d;
  logic [NSRC*SW-1:0]       cand_sel;
  logic [NSRC-1:0]          hazard;
  logic                     rd_trackable;
  logic                     push;
  logic                     issue;

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    fwd_match #(
      .AW(AW), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .SW(SW), .EW(EW)
    ) u_match (
      .src    (id_src[i*AW +: AW]),
      .src_en (id_valid & id_src_used[i]),
      .ent    (ent_q),
      .sel    (cand_sel[i*SW +: SW]),
      .hazard (hazard[i])
    );
  end

  // Stall and accept decisions; flush wins over stall.
  always_comb begin
    stall        = (|hazard) & ~flush;
    rd_trackable = (id_rd != '0) && (int'(id_rd) < NREG);
    push         = id_valid & id_we & rd_trackable & ~stall & ~flush;
    issue        = id_valid & ~stall & ~flush;
  end

  // Next state: shift writers down the pipe, insert new writer or bubble.
  always_comb begin
    ent_d = '0;
    for (int k = DEPTH - 1; k > 0; k--) ent_d[k] = ent_q[k-1];
    ent_d[0][ENT_V]             = push;
    ent_d[0][ENT_LD]            = push & id_load;
    ent_d[0][ENT_RD_LSB +: AW]  = push ? id_rd : '0;
    ex_fwd_sel_d   = issue ? cand_sel : '0;
    stall_cycles_d = stall_cycles_q;
    if (stall && (stall_cycles_q != 16'hFFFF)) stall_cycles_d = stall_cycles_q + 16'd1;
  end

  // Number of valid tracked writers.
  always_comb begin
    busy_cnt = '0;
    for (int k = 0; k < DEPTH; k++) busy_cnt = busy_cnt + CW'(ent_q[k][ENT_V]);
  end

  // State registers, cleared immediately by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ent_q          <= '0;
      ex_fwd_sel_q   <= '0;
      stall_cycles_q <= '0;
    end else begin
      ent_q          <= ent_d;
      ex_fwd_sel_q   <= ex_fwd_sel_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign ex_fwd_sel   = ex_fwd_sel_q;
  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Bench for fwd_scoreboard: default-parameter instance driven from a vector
// table plus hand sequences, and a deep instance used for counter saturation.
module tb_fwd_scoreboard;
  import fwd_scoreboard_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT (defaults) ----------------
  logic        id_valid, id_we, id_load, flush;
  logic [4:0]  id_rd;
  logic [9:0]  id_src;
  logic [1:0]  id_src_used;
  logic        stall;
  logic [3:0]  ex_fwd_sel;
  logic [1:0]  busy_cnt;
  logic [15:0] stall_cycles;

  fwd_scoreboard u_dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rd(id_rd), .id_we(id_we),
    .id_load(id_load), .id_src(id_src), .id_src_used(id_src_used), .flush(flush),
    .stall(stall), .ex_fwd_sel(ex_fwd_sel), .busy_cnt(busy_cnt),
    .stall_cycles(stall_cycles)
  );

  // ---------------- deep DUT for saturation ----------------
  logic        s_valid, s_we, s_load, s_flush;
  logic [4:0]  s_rd;
  logic [9:0]  s_src;
  logic [1:0]  s_used;
  logic        s_stall;
  logic [7:0]  s_fwd_sel;
  logic [4:0]  s_busy;
  logic [15:0] s_cycles;

  fwd_scoreboard #(.DEPTH(16), .LOAD_LAT(16)) u_sat (
    .clk(clk), .rst(rst), .id_valid(s_valid), .id_rd(s_rd), .id_we(s_we),
    .id_load(s_load), .id_src(s_src), .id_src_used(s_used), .flush(s_flush),
    .stall(s_stall), .ex_fwd_sel(s_fwd_sel), .busy_cnt(s_busy),
    .stall_cycles(s_cycles)
  );

  // ---------------- scoreboard / counters ----------------
  logic [3:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string      name;
    logic       v;
    logic [4:0] rd;
    logic       we;
    logic       ld;
    logic [4:0] s0;
    logic [4:0] s1;
    logic [1:0] used;
    logic       fl;
    logic       exp_stall;
    logic [1:0] exp_sel0;
    logic [1:0] exp_sel1;
    logic [1:0] exp_busy;
    logic [15:0] exp_scyc;
  } vec_t;

  localparam int NV = 27;
  vec_t vecs[NV];

  function automatic vec_t mk(input string nm, input logic v, input logic [4:0] rd,
                              input logic we, input logic ld, input logic [4:0] s0,
                              input logic [4:0] s1, input logic [1:0] used, input logic fl,
                              input logic es, input logic [1:0] e0, input logic [1:0] e1,
                              input logic [1:0] eb, input logic [15:0] ec);
    vec_t r;
    r.name = nm; r.v = v; r.rd = rd; r.we = we; r.ld = ld; r.s0 = s0; r.s1 = s1;
    r.used = used; r.fl = fl; r.exp_stall = es; r.exp_sel0 = e0; r.exp_sel1 = e1;
    r.exp_busy = eb; r.exp_scyc = ec;
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_id(input logic v, input logic [4:0] rd, input logic we, input logic ld,
                          input logic [4:0] s0, input logic [4:0] s1, input logic [1:0] used,
                          input logic fl);
    id_valid = v; id_rd = rd; id_we = we; id_load = ld;
    id_src = {s1, s0}; id_src_used = used; flush = fl;
  endtask

  task automatic apply_vec(input vec_t t);
    logic [3:0] exp_sel;
    drive_id(t.v, t.rd, t.we, t.ld, t.s0, t.s1, t.used, t.fl);
    #1;
    check({t.name, "/stall"}, 32'(stall), 32'(t.exp_stall));
    check({t.name, "/busy_cnt"}, 32'(busy_cnt), 32'(t.exp_busy));
    check({t.name, "/stall_cycles"}, 32'(stall_cycles), 32'(t.exp_scyc));
    exp_q.push_back({t.exp_sel1, t.exp_sel0});
    @(negedge clk);
    exp_sel = exp_q.pop_front();
    check({t.name, "/ex_fwd_sel"}, 32'(ex_fwd_sel), 32'(exp_sel));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1500000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main test ----------------
  initial begin
    drive_id(0, 0, 0, 0, 0, 0, 2'b00, 0);
    s_valid = 0; s_rd = 0; s_we = 0; s_load = 0; s_src = '0; s_used = 0; s_flush = 0;

    // name                 v  rd  we ld  s0  s1  used   fl  stall sel0 sel1 busy scyc
    vecs[0]  = mk("alu_r3",          1, 3, 1, 0,  1,  2, 2'b11, 0, 0, 0, 0, 0, 0);
    vecs[1]  = mk("fwd_exmem",       1, 4, 1, 0,  3,  1, 2'b11, 0, 0, 1, 0, 1, 0);
    vecs[2]  = mk("lw_r5",           1, 5, 1, 1,  2,  0, 2'b01, 0, 0, 0, 0, 2, 0);
    vecs[3]  = mk("load_use_stall",  1, 6, 1, 0,  1,  5, 2'b11, 0, 1, 0, 0, 3, 0);
    vecs[4]  = mk("load_use_retry",  1, 6, 1, 0,  1,  5, 2'b11, 0, 0, 0, 2, 2, 1);
    vecs[5]  = mk("lw_r8",           1, 8, 1, 1,  1,  0, 2'b01, 0, 0, 0, 0, 2, 1);
    vecs[6]  = mk("independent",     1, 9, 1, 0,  1,  2, 2'b11, 0, 0, 0, 0, 2, 1);
    vecs[7]  = mk("use_r8_memwb",    1, 10, 1, 0, 8,  1, 2'b11, 0, 0, 2, 0, 3, 1);
    vecs[8]  = mk("use_r8_rf",       1, 11, 1, 0, 1,  8, 2'b11, 0, 0, 0, 0, 3, 1);
    vecs[9]  = mk("w_r7_a",          1, 7, 1, 0,  1,  2, 2'b11, 0, 0, 0, 0, 3, 1);
    vecs[10] = mk("w_r7_b",          1, 7, 1, 0,  1,  2, 2'b11, 0, 0, 0, 0, 3, 1);
    vecs[11] = mk("youngest_r7",     1, 12, 1, 0, 7,  7, 2'b11, 0, 0, 1, 1, 3, 1);
    vecs[12] = mk("r0_and_unused",   1, 0, 1, 0,  0, 12, 2'b01, 0, 0, 0, 0, 3, 1);
    vecs[13] = mk("r0_not_tracked",  1, 14, 1, 0, 0, 12, 2'b11, 0, 0, 0, 2, 2, 1);
    vecs[14] = mk("store_no_we",     1, 15, 0, 0, 14, 12, 2'b11, 0, 0, 1, 0, 2, 1);
    vecs[15] = mk("r15_not_written", 1, 16, 1, 0, 15, 14, 2'b11, 0, 0, 0, 2, 1, 1);
    vecs[16] = mk("lw_r5_again",     1, 5, 1, 1,  1,  0, 2'b01, 0, 0, 0, 0, 2, 1);
    vecs[17] = mk("flush_hazard",    1, 6, 1, 0,  1,  5, 2'b11, 1, 0, 0, 0, 2, 1);
    vecs[18] = mk("idle_a",          0, 6, 1, 0,  1,  5, 2'b11, 0, 0, 0, 0, 2, 1);
    vecs[19] = mk("idle_b",          0, 6, 1, 0,  1,  5, 2'b11, 0, 0, 0, 0, 1, 1);
    vecs[20] = mk("idle_c",          0, 6, 1, 0,  1,  5, 2'b11, 0, 0, 0, 0, 0, 1);
    vecs[21] = mk("lw_r20",          1, 20, 1, 1, 1,  0, 2'b01, 0, 0, 0, 0, 0, 1);
    vecs[22] = mk("load_use_both",   1, 21, 1, 0, 20, 20, 2'b11, 0, 1, 0, 0, 1, 1);
    vecs[23] = mk("retry_both",      1, 21, 1, 0, 20, 20, 2'b11, 0, 0, 2, 2, 1, 2);
    vecs[24] = mk("lw_r22",          1, 22, 1, 1, 1,  0, 2'b01, 0, 0, 0, 0, 2, 2);
    vecs[25] = mk("invalid_no_stall",0, 23, 1, 0, 22, 22, 2'b11, 0, 0, 0, 0, 2, 2);
    vecs[26] = mk("after_invalid",   1, 23, 1, 0, 1, 22, 2'b11, 0, 0, 0, 2, 2, 2);

    // Reset state
    repeat (3) @(negedge clk);
    check("reset/stall", 32'(stall), 0);
    check("reset/busy_cnt", 32'(busy_cnt), 0);
    check("reset/ex_fwd_sel", 32'(ex_fwd_sel), 0);
    check("reset/stall_cycles", 32'(stall_cycles), 0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NV; i++) apply_vec(vecs[i]);

    // Asynchronous reset in the middle of a stalled cycle with 3 writers
    drive_id(1, 1, 1, 0, 0, 0, 2'b00, 0);
    @(negedge clk);
    drive_id(1, 2, 1, 0, 0, 0, 2'b00, 0);
    @(negedge clk);
    drive_id(1, 3, 1, 1, 2, 0, 2'b01, 0);
    @(negedge clk);
    drive_id(1, 4, 1, 0, 3, 0, 2'b01, 0);
    #1;
    check("pre_rst/busy_cnt", 32'(busy_cnt), 3);
    check("pre_rst/stall", 32'(stall), 1);
    check("pre_rst/ex_fwd_sel", 32'(ex_fwd_sel), 32'h1);
    #2 rst = 1'b0;
    #1;
    check("mid_rst/busy_cnt", 32'(busy_cnt), 0);
    check("mid_rst/stall", 32'(stall), 0);
    check("mid_rst/ex_fwd_sel", 32'(ex_fwd_sel), 0);
    check("mid_rst/stall_cycles", 32'(stall_cycles), 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("post_rst/stall", 32'(stall), 0);
    @(negedge clk);
    check("post_rst/ex_fwd_sel", 32'(ex_fwd_sel), 0);
    check("post_rst/busy_cnt", 32'(busy_cnt), 1);
    check("post_rst/stall_cycles", 32'(stall_cycles), 0);
    drive_id(0, 0, 0, 0, 0, 0, 2'b00, 0);

    // Saturation: a self-dependent load held in ID stalls 15 of every 16
    // cycles in the deep instance.
    s_valid = 1; s_rd = 5; s_we = 1; s_load = 1; s_src = {5'd0, 5'd5}; s_used = 2'b01;
    repeat (16) @(negedge clk);
    check("sat/early_count", 32'(s_cycles), 15);
    check("sat/reenter_stall", 32'(s_stall), 0);
    check("sat/busy_cnt", 32'(s_busy), 1);
    @(negedge clk);
    check("sat/restall", 32'(s_stall), 1);
    repeat (69983) @(negedge clk);
    check("sat/saturated", 32'(s_cycles), 32'hFFFF);
    repeat (20) @(negedge clk);
    check("sat/held", 32'(s_cycles), 32'hFFFF);
    s_valid = 0;

    check("scoreboard/drained", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
